// File: rtl/sata_oob_ctrl_if.sv
// GTX-facing OOB and parallel data bundle for the SATA link controller.
// master = controller side, slave = transceiver side.
interface sata_oob_ctrl_if;
    logic        tx_cominit;
    logic        tx_comwake;
    logic        tx_comfinish;
    logic        rx_cominit_det;
    logic        rx_comwake_det;
    logic [31:0] rx_data;
    logic [3:0]  rx_charisk;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk;
    logic        tx_elecidle;

    modport master (
        output tx_cominit, tx_comwake, tx_data, tx_charisk, tx_elecidle,
        input  tx_comfinish, rx_cominit_det, rx_comwake_det, rx_data, rx_charisk
    );

    modport slave (
        input  tx_cominit, tx_comwake, tx_data, tx_charisk, tx_elecidle,
        output tx_comfinish, rx_cominit_det, rx_comwake_det, rx_data, rx_charisk
    );
endinterface

// File: rtl/sata_oob_ctrl.sv
// SATA host OOB bring-up FSM: COMRESET/COMWAKE handshake, ALIGN/SYNC lock, timeout retry.
// One-cycle state latency; outputs decode from registered state, no backpressure.
module sata_oob_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 132000,
    parameter int unsigned ALIGN_CNT   = 3,
    parameter int unsigned MAX_RETRY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gtx_ready,
    input  logic                  restart,
    sata_oob_ctrl_if.master       phy,
    output logic                  link_up,
    output logic                  link_fail,
    output logic [3:0]            state,
    output logic [3:0]            retry_cnt
);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_COMRESET     = 4'd1,
        ST_WAIT_COMINIT = 4'd2,
        ST_COMWAKE      = 4'd3,
        ST_WAIT_COMWAKE = 4'd4,
        ST_WAIT_ALIGN   = 4'd5,
        ST_SEND_ALIGN   = 4'd6,
        ST_LINK_UP      = 4'd7,
        ST_FAIL         = 4'd8
    } st_t;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_D102  = 32'h4A4A_4A4A;
    localparam logic [23:0] TMO_LAST   = 24'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  MATCH_MAX  = 4'(ALIGN_CNT);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

    st_t         st_q, st_nxt;
    logic [23:0] timer_q;
    logic [3:0]  retry_q, retry_nxt;
    logic [3:0]  match_q, match_nxt, match_inc;
    logic        fresh_q;
    logic        take, adv, tmo, timed, is_align, is_sync;

    assign timed     = (st_q >= ST_COMRESET) && (st_q <= ST_SEND_ALIGN);
    assign tmo       = timed && (timer_q == TMO_LAST);
    assign is_align  = (phy.rx_data == PRIM_ALIGN) && (phy.rx_charisk == 4'b0001);
    assign is_sync   = (phy.rx_data == PRIM_SYNC)  && (phy.rx_charisk == 4'b0001);
    assign match_inc = (match_q == MATCH_MAX) ? match_q : match_q + 4'd1;

    always_comb begin
        st_nxt    = st_q;
        retry_nxt = retry_q;
        match_nxt = match_q;
        take      = 1'b0;
        adv       = 1'b0;
        if (!gtx_ready) begin
            st_nxt = ST_IDLE;
            take   = (st_q != ST_IDLE);
        end else if (restart) begin
            st_nxt    = ST_COMRESET;
            retry_nxt = 4'd0;
            take      = 1'b1;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    st_nxt    = ST_COMRESET;
                    retry_nxt = 4'd0;
                    adv       = 1'b1;
                end
                ST_COMRESET:     if (phy.tx_comfinish)   begin st_nxt = ST_WAIT_COMINIT; adv = 1'b1; end
                ST_WAIT_COMINIT: if (phy.rx_cominit_det) begin st_nxt = ST_COMWAKE;      adv = 1'b1; end
                ST_COMWAKE:      if (phy.tx_comfinish)   begin st_nxt = ST_WAIT_COMWAKE; adv = 1'b1; end
                ST_WAIT_COMWAKE: if (phy.rx_comwake_det) begin st_nxt = ST_WAIT_ALIGN;   adv = 1'b1; end
                ST_WAIT_ALIGN: begin
                    match_nxt = is_align ? match_inc : 4'd0;
                    if (is_align && match_inc == MATCH_MAX) begin
                        st_nxt = ST_SEND_ALIGN;
                        adv    = 1'b1;
                    end
                end
                ST_SEND_ALIGN: begin
                    match_nxt = is_sync ? match_inc : 4'd0;
                    if (is_sync && match_inc == MATCH_MAX) begin
                        st_nxt = ST_LINK_UP;
                        adv    = 1'b1;
                    end
                end
                ST_LINK_UP:      if (phy.rx_cominit_det) begin st_nxt = ST_COMWAKE;      adv = 1'b1; end
                ST_FAIL: ;
                default: begin
                    st_nxt = ST_IDLE;
                    adv    = 1'b1;
                end
            endcase
            // An advancing event on the timeout cycle wins over the retry.
            if (adv) begin
                take = 1'b1;
            end else if (tmo) begin
                take = 1'b1;
                if (retry_q < RETRY_MAX) begin
                    st_nxt    = ST_COMRESET;
                    retry_nxt = retry_q + 4'd1;
                end else begin
                    st_nxt = ST_FAIL;
                end
            end
        end
        if (take && st_nxt == ST_LINK_UP) retry_nxt = 4'd0;
        if (take) match_nxt = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            timer_q <= 24'd0;
            retry_q <= 4'd0;
            match_q <= 4'd0;
            fresh_q <= 1'b0;
        end else begin
            st_q    <= st_nxt;
            retry_q <= retry_nxt;
            match_q <= match_nxt;
            // fresh_q marks the first cycle after any entry, including timeout re-entry of COMRESET.
            fresh_q <= take;
            if (take)       timer_q <= 24'd0;
            else if (timed) timer_q <= timer_q + 24'd1;
        end
    end

    always_comb begin
        phy.tx_data    = 32'd0;
        phy.tx_charisk = 4'd0;
        case (st_q)
            ST_WAIT_ALIGN: begin phy.tx_data = PRIM_D102;  phy.tx_charisk = 4'b0000; end
            ST_SEND_ALIGN: begin phy.tx_data = PRIM_ALIGN; phy.tx_charisk = 4'b0001; end
            ST_LINK_UP:    begin phy.tx_data = PRIM_SYNC;  phy.tx_charisk = 4'b0001; end
            default: ;
        endcase
    end

    assign phy.tx_cominit  = (st_q == ST_COMRESET) && fresh_q;
    assign phy.tx_comwake  = (st_q == ST_COMWAKE)  && fresh_q;
    assign phy.tx_elecidle = !((st_q >= ST_WAIT_ALIGN) && (st_q <= ST_LINK_UP));
    assign link_up         = (st_q == ST_LINK_UP);
    assign link_fail       = (st_q == ST_FAIL);
    assign state           = st_q;
    assign retry_cnt       = retry_q;

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// Directed bench for sata_oob_ctrl with TIMEOUT_CYC=64, ALIGN_CNT=3, MAX_RETRY=2.
module tb_sata_oob_ctrl;
    localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] D102  = 32'h4A4A_4A4A;

    logic       clk = 1'b0;
    logic       rst, gtx_ready, restart;
    logic       link_up, link_fail;
    logic [3:0] state, retry_cnt;
    int         checks = 0;
    int         errors = 0;
    int         n_cominit = 0;
    int         n_comwake = 0;
    int         c0, w0;

    sata_oob_ctrl_if phy ();

    sata_oob_ctrl #(.TIMEOUT_CYC(64), .ALIGN_CNT(3), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .gtx_ready (gtx_ready),
        .restart   (restart),
        .phy       (phy.master),
        .link_up   (link_up),
        .link_fail (link_fail),
        .state     (state),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (phy.tx_cominit) n_cominit++;
        if (phy.tx_comwake) n_comwake++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [31:0] d, input logic [3:0] k);
        phy.rx_data    = d;
        phy.rx_charisk = k;
        tick();
        phy.rx_data    = 32'd0;
        phy.rx_charisk = 4'd0;
    endtask

    task automatic pulse_finish();
        phy.tx_comfinish = 1'b1; tick(); phy.tx_comfinish = 1'b0;
    endtask

    task automatic pulse_cominit();
        phy.rx_cominit_det = 1'b1; tick(); phy.rx_cominit_det = 1'b0;
    endtask

    task automatic pulse_comwake();
        phy.rx_comwake_det = 1'b1; tick(); phy.rx_comwake_det = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gtx_ready = 1'b1; restart = 1'b0;
        phy.tx_comfinish = 1'b0; phy.rx_cominit_det = 1'b0; phy.rx_comwake_det = 1'b0;
        phy.rx_data = 32'd0; phy.rx_charisk = 4'd0;
        tick(); tick();
        chk("rst_state",    32'(state), 32'd0);
        chk("rst_elecidle", 32'(phy.tx_elecidle), 32'd1);
        chk("rst_txdata",   phy.tx_data, 32'd0);
        chk("rst_linkup",   32'(link_up), 32'd0);
        chk("rst_retry",    32'(retry_cnt), 32'd0);
        chk("rst_cominit",  32'(phy.tx_cominit), 32'd0);

        // Nominal bring-up
        c0 = n_cominit; w0 = n_comwake;
        rst = 1'b0;
        tick();
        chk("nom_s1", 32'(state), 32'd1);
        chk("nom_cominit_first", 32'(phy.tx_cominit), 32'd1);
        tick();
        chk("nom_cominit_once", 32'(phy.tx_cominit), 32'd0);
        pulse_finish();
        chk("nom_s2", 32'(state), 32'd2);
        pulse_cominit();
        chk("nom_s3", 32'(state), 32'd3);
        chk("nom_comwake_first", 32'(phy.tx_comwake), 32'd1);
        pulse_finish();
        chk("nom_s4", 32'(state), 32'd4);
        pulse_comwake();
        chk("nom_s5", 32'(state), 32'd5);
        chk("nom_d102", phy.tx_data, D102);
        chk("nom_elecidle5", 32'(phy.tx_elecidle), 32'd0);

        // Broken ALIGN run restarts the count
        word(ALIGN, 4'b0001); chk("al_1", 32'(state), 32'd5);
        word(ALIGN, 4'b0001); chk("al_2", 32'(state), 32'd5);
        word(D102,  4'b0000); chk("al_brk", 32'(state), 32'd5);
        word(ALIGN, 4'b0001); chk("al_3", 32'(state), 32'd5);
        word(ALIGN, 4'b0001); chk("al_4", 32'(state), 32'd5);
        word(ALIGN, 4'b0001); chk("al_5", 32'(state), 32'd6);
        chk("sa_txdata", phy.tx_data, ALIGN);
        word(SYNC, 4'b0001); chk("sy_1", 32'(state), 32'd6);
        word(SYNC, 4'b0001); chk("sy_2", 32'(state), 32'd6);
        word(SYNC, 4'b0001); chk("sy_3", 32'(state), 32'd7);
        chk("lu_linkup",  32'(link_up), 32'd1);
        chk("lu_txdata",  phy.tx_data, SYNC);
        chk("lu_charisk", 32'(phy.tx_charisk), 32'd1);
        chk("lu_n_cominit", 32'(n_cominit - c0), 32'd1);
        chk("lu_n_comwake", 32'(n_comwake - w0), 32'd1);

        // Device-initiated re-init from LINK_UP
        pulse_cominit();
        chk("reinit_s3",      32'(state), 32'd3);
        chk("reinit_comwake", 32'(phy.tx_comwake), 32'd1);
        chk("reinit_linkup",  32'(link_up), 32'd0);
        chk("reinit_elecidle", 32'(phy.tx_elecidle), 32'd1);

        // gtx_ready drop in SEND_ALIGN
        pulse_finish();
        pulse_comwake();
        for (int i = 0; i < 3; i++) word(ALIGN, 4'b0001);
        chk("gr_s6", 32'(state), 32'd6);
        gtx_ready = 1'b0; tick();
        chk("gr_idle", 32'(state), 32'd0);
        gtx_ready = 1'b1; tick();
        chk("gr_s1", 32'(state), 32'd1);

        // Timeouts in WAIT_COMINIT run out the retry budget
        pulse_finish();
        chk("to_s2", 32'(state), 32'd2);
        for (int i = 0; i < 63; i++) tick();
        chk("to_hold63", 32'(state), 32'd2);
        tick();
        chk("to1_state", 32'(state), 32'd1);
        chk("to1_retry", 32'(retry_cnt), 32'd1);
        chk("to1_cominit", 32'(phy.tx_cominit), 32'd1);
        pulse_finish();
        for (int i = 0; i < 64; i++) tick();
        chk("to2_state", 32'(state), 32'd1);
        chk("to2_retry", 32'(retry_cnt), 32'd2);
        pulse_finish();
        for (int i = 0; i < 64; i++) tick();
        chk("to3_state", 32'(state), 32'd8);
        chk("to3_fail",  32'(link_fail), 32'd1);
        chk("to3_elecidle", 32'(phy.tx_elecidle), 32'd1);
        for (int i = 0; i < 70; i++) tick();
        chk("fail_hold", 32'(state), 32'd8);

        // Restart out of FAIL
        restart = 1'b1; tick(); restart = 1'b0;
        chk("rs_state", 32'(state), 32'd1);
        chk("rs_retry", 32'(retry_cnt), 32'd0);
        chk("rs_cominit", 32'(phy.tx_cominit), 32'd1);

        // Timeout coincident with COMWAKE detect
        pulse_finish();
        pulse_cominit();
        pulse_finish();
        chk("co_s4", 32'(state), 32'd4);
        for (int i = 0; i < 63; i++) tick();
        chk("co_hold", 32'(state), 32'd4);
        pulse_comwake();
        chk("co_state", 32'(state), 32'd5);
        chk("co_retry", 32'(retry_cnt), 32'd0);

        // Reset out of LINK_UP with a COMINIT pending
        for (int i = 0; i < 3; i++) word(ALIGN, 4'b0001);
        for (int i = 0; i < 3; i++) word(SYNC, 4'b0001);
        chk("rl_s7", 32'(state), 32'd7);
        rst = 1'b1; phy.rx_cominit_det = 1'b1;
        tick();
        chk("rl_state",   32'(state), 32'd0);
        chk("rl_comwake", 32'(phy.tx_comwake), 32'd0);
        chk("rl_linkup",  32'(link_up), 32'd0);
        chk("rl_txdata",  phy.tx_data, 32'd0);
        chk("rl_elecidle", 32'(phy.tx_elecidle), 32'd1);
        rst = 1'b0; phy.rx_cominit_det = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
